// File: rtl/codec_cfg_seq_if.sv
// Command/completion handshake between the codec configuration sequencer
// (master) and the downstream I2C master (slave).
interface codec_cfg_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_data;
  logic        xfer_done;
  logic        xfer_nack;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  xfer_done,
    input  xfer_nack
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output xfer_done,
    output xfer_nack
  );
endinterface

// File: rtl/codec_cfg_seq.sv
// Writes an 11-entry register table to an audio codec through an I2C master.
// Define CFG_RETRY_EN to retry a NACKed register up to MAX_RETRY times before aborting.
module codec_cfg_seq #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  codec_cfg_seq_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [3:0]             reg_index
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_range
    $error("GAP_CYCLES must lie in 1..255");
  end
  if (MAX_RETRY > 255) begin : g_retry_range
    $error("MAX_RETRY must not exceed 255");
  end

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, GAP, DONE, ERR} state_e;

  localparam logic [3:0] LAST_INDEX = 4'd10;

  // NOTE: the table is a constant ROM decoded from reg_index, so it has no
  // storage of its own and needs no reset.
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    logic [15:0] entry;  // {reg_addr[6:0], reg_data[8:0]}
    case (idx)
      4'd0:    entry = {7'd15, 9'h000};
      4'd1:    entry = {7'd0,  9'h017};
      4'd2:    entry = {7'd1,  9'h017};
      4'd3:    entry = {7'd2,  9'h079};
      4'd4:    entry = {7'd3,  9'h079};
      4'd5:    entry = {7'd4,  9'h012};
      4'd6:    entry = {7'd5,  9'h000};
      4'd7:    entry = {7'd6,  9'h000};
      4'd8:    entry = {7'd7,  9'h00A};
      4'd9:    entry = {7'd8,  9'h000};
      4'd10:   entry = {7'd9,  9'h001};
      default: entry = 16'h0000;
    endcase
    return entry;
  endfunction

  state_e      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [23:0] cmd_data_q, cmd_data_d;
  logic [3:0]  reg_index_q, reg_index_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef CFG_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    reg_index_d = reg_index_q;
    gap_cnt_d   = gap_cnt_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef CFG_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d     = LOAD;
          done_d      = 1'b0;
          error_d     = 1'b0;
          reg_index_d = 4'd0;
`ifdef CFG_RETRY_EN
          retry_d     = '0;
`endif
        end
      end
      LOAD: begin
        cmd_data_d  = {DEV_ADDR, 1'b0, table_entry(reg_index_q)};
        cmd_valid_d = 1'b1;
        state_d     = REQ;
      end
      REQ: begin
        if (bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.xfer_done) begin
          if (!bus.xfer_nack) begin
            gap_cnt_d = 8'd0;
            state_d   = GAP;
`ifdef CFG_RETRY_EN
            retry_d   = '0;
`endif
          end else begin
`ifdef CFG_RETRY_EN
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = LOAD;
            end else begin
              error_d = 1'b1;
              state_d = ERR;
            end
`else
            error_d = 1'b1;
            state_d = ERR;
`endif
          end
        end
      end
      GAP: begin
        // The count runs 0..GAP_CYCLES-1, so GAP lasts exactly GAP_CYCLES cycles.
        if (gap_cnt_q == 8'(GAP_CYCLES - 1)) begin
          if (reg_index_q == LAST_INDEX) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            reg_index_d = reg_index_q + 4'd1;
            state_d     = LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = state_d inside {LOAD, REQ, WAIT, GAP};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= 24'h0;
      reg_index_q <= 4'd0;
      gap_cnt_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef CFG_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      reg_index_q <= reg_index_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef CFG_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_data  = cmd_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign reg_index     = reg_index_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed bench for codec_cfg_seq: a behavioural I2C-master responder plus
// per-scenario tasks with hand-computed expected commands and timing.
module tb_codec_cfg_seq;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, error;
  logic [3:0] reg_index;

  int tests = 0;
  int fails = 0;

  codec_cfg_seq_if bus ();

  codec_cfg_seq #(
    .DEV_ADDR  (7'h1A),
    .GAP_CYCLES(GAP),
    .MAX_RETRY (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .reg_index(reg_index)
  );

  always #5 clk = ~clk;

  // {DEV_ADDR=0x1A, 0, reg_addr[6:0], reg_data[8:0]} worked out by hand per entry.
  logic [23:0] exp_cmd [11] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479,
                                24'h340679, 24'h340812, 24'h340A00, 24'h340C00,
                                24'h340E0A, 24'h341000, 24'h341201};

  logic [23:0] cmds [$];
  int          gap_err;
  bit          timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_cmd(input logic [23:0] value);
    int n = 0;
    foreach (cmds[i]) if (cmds[i] === value) n++;
    return n;
  endfunction

  // Responder: accepts every command on the cycle it is seen, answers with
  // xfer_done three samples later, NACKs entry nack_idx nack_count times.
  // The next command must rise GAP+2 samples after an ACK (GAP + LOAD + REQ edge).
  // stray injects a NACKed xfer_done plus start inside each gap and start in REQ.
  // stop_idx returns with the DUT in WAIT for that entry.
  task automatic run_master(input int nack_idx, input int nack_count,
                            input bit stray, input int stop_idx);
    int pend = 0;
    int nacks_left = nack_count;
    int cur_idx = -1;
    int last_ack = -1;
    bit prev_valid = 1'b0;
    bit stop_next = 1'b0;
    cmds.delete();
    gap_err = 0;
    timeout = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (stop_next || done || error) begin
        timeout = 1'b0;
        break;
      end
      start         = 1'b0;
      bus.xfer_done = 1'b0;
      bus.xfer_nack = 1'b0;
      if (pend == 1) begin
        bus.xfer_done = 1'b1;
        if (cur_idx == nack_idx && nacks_left > 0) begin
          bus.xfer_nack = 1'b1;
          nacks_left--;
          last_ack = -1;
        end else begin
          last_ack = c;
        end
        pend = 0;
      end else if (pend > 1) begin
        pend--;
      end else if (stray && last_ack >= 0 && c == last_ack + 2) begin
        bus.xfer_done = 1'b1;
        bus.xfer_nack = 1'b1;
        start         = 1'b1;
      end
      if (bus.cmd_valid === 1'b1 && !prev_valid) begin
        if (last_ack >= 0 && (c - last_ack) != GAP + 2) gap_err++;
        bus.cmd_ready = 1'b1;
        cmds.push_back(bus.cmd_data);
        cur_idx = int'(reg_index);
        pend = 3;
        if (stray) start = 1'b1;
        if (cur_idx == stop_idx) stop_next = 1'b1;
      end
      prev_valid = (bus.cmd_valid === 1'b1);
      tick();
    end
    start         = 1'b0;
    bus.xfer_done = 1'b0;
    bus.xfer_nack = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b1;
    start = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.xfer_done = 1'b0;
    bus.xfer_nack = 1'b0;
    tick();
    tick();
    tests++;
    if ({bus.cmd_valid, busy, done, error} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: valid/busy/done/error=%b required 0000",
               {bus.cmd_valid, busy, done, error});
    end
    tests++;
    if (bus.cmd_data !== 24'h0 || reg_index !== 4'd0) begin
      fails++;
      $display("FAIL reset_data: cmd_data=%h reg_index=%0d required 000000/0",
               bus.cmd_data, reg_index);
    end
    reset = 1'b0;
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.xfer_done = i[0];
      tick();
      if ({bus.cmd_valid, busy, done, error} !== 4'b0000 || bus.cmd_data !== 24'h0 ||
          reg_index !== 4'd0) bad++;
    end
    bus.xfer_done = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_after_reset: %0d cycles with nonzero outputs, required 0", bad);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    tests++;
    if (bus.cmd_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_latency_1: valid=%b busy=%b required 0/1", bus.cmd_valid, busy);
    end
    tick();
    tests++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== 24'h341E00) begin
      fails++;
      $display("FAIL start_latency_2: valid=%b data=%h required 1/341e00",
               bus.cmd_valid, bus.cmd_data);
    end
    run_master(-1, 0, 1'b0, -1);
    tests++;
    if (timeout || cmds.size() != 11) begin
      fails++;
      $display("FAIL basic_count: timeout=%b cmds=%0d required 0/11", timeout, cmds.size());
    end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (cmds[i] !== exp_cmd[i]) begin
        fails++;
        $display("FAIL basic_cmd[%0d]: got %h required %h", i, cmds[i], exp_cmd[i]);
      end
    end
    tests++;
    if ({done, busy, error} !== 3'b100 || reg_index !== 4'd10 || gap_err != 0) begin
      fails++;
      $display("FAIL basic_end: done/busy/error=%b idx=%0d gap_err=%0d required 100/10/0",
               {done, busy, error}, reg_index, gap_err);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_clears_done: done=%b busy=%b required 0/1", done, busy);
    end
    tick();
    run_master(-1, 0, 1'b1, -1);
    tests++;
    if (timeout || cmds.size() != 11 || cmds[10] !== 24'h341201) begin
      fails++;
      $display("FAIL stray_count: timeout=%b cmds=%0d required 0/11", timeout, cmds.size());
    end
    tests++;
    if (gap_err != 0 || {done, error} !== 2'b10) begin
      fails++;
      $display("FAIL stray_gaps: gap_err=%0d done/error=%b required 0/10",
               gap_err, {done, error});
    end
  endtask

  task automatic test_stall();
    logic [23:0] held;
    int bad = 0;
    int extra = 0;
    bus.cmd_ready = 1'b0;
    pulse_start();
    tick();
    held = bus.cmd_data;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== held) bad++;
      tick();
    end
    tests++;
    if (bad != 0 || held !== 24'h341E00) begin
      fails++;
      $display("FAIL stall_hold: %0d unstable cycles, data=%h required 0/341e00", bad, held);
    end
    bus.cmd_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (bus.cmd_valid !== 1'b0) extra++;
      tick();
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL stall_single_handshake: valid high %0d cycles after accept, required 0",
               extra);
    end
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    run_master(-1, 0, 1'b0, -1);
    tests++;
    if (cmds.size() != 10 || cmds[0] !== 24'h340017 || done !== 1'b1) begin
      fails++;
      $display("FAIL stall_finish: cmds=%0d first=%h done=%b required 10/340017/1",
               cmds.size(), cmds[0], done);
    end
  endtask

  task automatic test_nack();
`ifdef CFG_RETRY_EN
    pulse_start();
    tick();
    run_master(3, 2, 1'b0, -1);
    tests++;
    if (count_cmd(24'h340479) != 3 || cmds.size() != 13 || {done, error} !== 2'b10) begin
      fails++;
      $display("FAIL retry_recover: issues=%0d cmds=%0d done/error=%b required 3/13/10",
               count_cmd(24'h340479), cmds.size(), {done, error});
    end
    pulse_start();
    tick();
    run_master(3, 4, 1'b0, -1);
    tests++;
    if (count_cmd(24'h340479) != 4 || cmds.size() != 7 || {done, error} !== 2'b01 ||
        reg_index !== 4'd3) begin
      fails++;
      $display("FAIL retry_exhaust: issues=%0d cmds=%0d done/error=%b idx=%0d required 4/7/01/3",
               count_cmd(24'h340479), cmds.size(), {done, error}, reg_index);
    end
`else
    int extra = 0;
    pulse_start();
    tick();
    run_master(5, 1, 1'b0, -1);
    tests++;
    if ({done, error, busy} !== 3'b010 || reg_index !== 4'd5 || cmds.size() != 6) begin
      fails++;
      $display("FAIL nack_abort: done/error/busy=%b idx=%0d cmds=%0d required 010/5/6",
               {done, error, busy}, reg_index, cmds.size());
    end
    for (int i = 0; i < 20; i++) begin
      bus.xfer_done = i[0];
      if (bus.cmd_valid !== 1'b0) extra++;
      tick();
    end
    bus.xfer_done = 1'b0;
    tests++;
    if (extra != 0 || error !== 1'b1) begin
      fails++;
      $display("FAIL nack_quiet: valid high %0d cycles, error=%b required 0/1", extra, error);
    end
`endif
  endtask

  task automatic test_reset_mid();
    pulse_start();
    tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_clears_error: error=%b busy=%b required 0/1", error, busy);
    end
    tick();
    run_master(-1, 0, 1'b0, 6);
    tests++;
    if (timeout || reg_index !== 4'd6 || busy !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_wait6: timeout=%b idx=%0d busy=%b valid=%b required 0/6/1/0",
               timeout, reg_index, busy, bus.cmd_valid);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.cmd_valid, busy, done, error} !== 4'b0000 || bus.cmd_data !== 24'h0 ||
        reg_index !== 4'd0) begin
      fails++;
      $display("FAIL async_reset: flags=%b data=%h idx=%0d required 0000/000000/0",
               {bus.cmd_valid, busy, done, error}, bus.cmd_data, reg_index);
    end
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    tick();
    tests++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== 24'h341E00 || reg_index !== 4'd0) begin
      fails++;
      $display("FAIL restart_entry0: valid=%b data=%h idx=%0d required 1/341e00/0",
               bus.cmd_valid, bus.cmd_data, reg_index);
    end
    run_master(-1, 0, 1'b0, -1);
    tests++;
    if (cmds.size() != 11 || done !== 1'b1) begin
      fails++;
      $display("FAIL restart_complete: cmds=%0d done=%b required 11/1", cmds.size(), done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_nack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, SHALL be the 7-bit I2C address of the audio codec.
REQ-002 Parameter GAP_CYCLES, default 16, SHALL be the idle clk cycles between consecutive writes (range 1..255).
REQ-003 Parameter MAX_RETRY, default 3, SHALL be the retries allowed per register after a NACK.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to run the configuration table.
REQ-007 cmd_valid  output  1  command to the downstream I2C master is valid.
REQ-008 cmd_ready  input  1  I2C master accepts the command.
REQ-009 cmd_data  output  24  {DEV_ADDR, 1'b0, reg_addr[6:0], reg_data[8:0]}, byte order MSB first.
REQ-010 xfer_done  input  1  single-cycle pulse when the I2C master finishes a transfer.
REQ-011 xfer_nack  input  1  qualifies xfer_done; 1 = any byte NACKed.
REQ-012 busy  output  1  sequence in progress.
REQ-013 done  output  1  all table entries written, sticky.
REQ-014 error  output  1  sequence aborted, sticky.
REQ-015 reg_index  output  4  index of current or last table entry.

Function
REQ-016 Internal table SHALL hold 11 entries (addr:data), in order: R15:000, R0:017, R1:017, R2:079, R3:079, R4:012, R5:000, R6:000, R7:00A, R8:000, R9:001.
REQ-017 States SHALL be IDLE, LOAD, REQ, WAIT, GAP, DONE, ERR.
REQ-018 IDLE/DONE/ERR + start=1 SHALL go to LOAD, clear done, error, reg_index and retry count.
REQ-019 LOAD SHALL register cmd_data from table[reg_index] and go to REQ; cmd_valid high from entry to REQ, i.e. on the 2nd rising edge after start is sampled.
REQ-020 REQ SHALL hold cmd_valid=1 and cmd_data stable until cmd_valid&cmd_ready, then deassert cmd_valid the next cycle and go to WAIT.
REQ-021 WAIT + xfer_done & !xfer_nack SHALL go to GAP with retry count cleared.
REQ-022 WAIT + xfer_done & xfer_nack SHALL be handled per REQ-032/REQ-033.
REQ-023 GAP SHALL count GAP_CYCLES cycles; then reg_index==10 goes to DONE, else reg_index+1 and LOAD.
REQ-024 DONE SHALL hold done=1; ERR SHALL hold error=1; done and error never both 1.
REQ-025 busy SHALL be 1 in LOAD, REQ, WAIT, GAP and 0 elsewhere.
REQ-026 start while busy SHALL be ignored.
REQ-027 xfer_done outside WAIT SHALL be ignored; cmd_ready outside REQ SHALL be ignored.
REQ-028 cmd_valid SHALL never be 1 outside REQ.

Reset
REQ-029 reset=1 SHALL immediately force IDLE and all outputs to 0 (cmd_data=24'h0, reg_index=0), regardless of state.
REQ-030 Reset mid-transfer SHALL abandon the transfer; a new start after release restarts at entry 0.
REQ-031 After reset release, outputs SHALL stay 0 until start.

Configuration
REQ-032 With CFG_RETRY_EN defined, NACK SHALL re-enter LOAD for the same reg_index while retry count < MAX_RETRY (count incremented), else go to ERR.
REQ-033 Without CFG_RETRY_EN, NACK SHALL go directly to ERR; MAX_RETRY unused and retry counter not synthesised.
REQ-034 In ERR, reg_index SHALL hold the failing entry.

Verification
REQ-035 start, master ready, always ACK -> 11 cmds, first 24'h341E00, second 24'h340017, last 24'h341201; done=1, busy=0.
REQ-036 cmd_ready held low 50 cycles in REQ -> cmd_valid stays 1, cmd_data unchanged all 50 cycles; one handshake only.
REQ-037 CFG_RETRY_EN, NACK on entry 3 twice then ACK -> 24'h340479 issued 3 times, sequence completes, done=1; NACK 4 times -> error=1, reg_index=3.
REQ-038 no CFG_RETRY_EN, NACK on entry 5 -> error=1, reg_index=5, no further cmd_valid.
REQ-039 reset pulsed while in WAIT for entry 6 -> all outputs 0 same cycle; next start reissues 24'h341E00 first.
REQ-040 start pulsed while busy and stray xfer_done in GAP -> sequence unaffected, exactly 11 commands, gaps exactly GAP_CYCLES.
